// File: rtl/glitch_free_clock_divider_pkg.sv
// Shared types and constants for the glitch-free clock divider.
package glitch_free_clock_divider_package;

   localparam int unsigned STOP_THRESHOLD = 2;
   localparam int unsigned IDLE_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      RUNNING  = 2'd0,
      DRAINING = 2'd1,
      IDLE_GAP = 2'd2
   } switch_state_e;

endpackage

// File: rtl/glitch_free_clock_divider_phase_counter.sv
// Phase counter: tracks the position of the next output cycle within the
// period and registers the high/low decision for that position.
module clock_divider_phase_counter
   import glitch_free_clock_divider_package::*;
#(
   parameter int unsigned DIVISOR_WIDTH = 8
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [DIVISOR_WIDTH-1:0] divisor_i,
   input  logic                     restart_i,
   input  logic                     force_low_i,
   output logic                     period_end_c_o,
   output logic                     clock_out_o
);

   localparam int unsigned DW = DIVISOR_WIDTH;

   logic [DW-1:0] phase_q, phase_d;
   logic [DW-1:0] pos_c, half_c, last_pos_c;
   logic          running_c;
   logic          out_q, out_d;

   // Emit the cycle at position pos_c and advance, wrapping at D-1.
   always_comb begin
      running_c      = (divisor_i >= DW'(STOP_THRESHOLD));
      half_c         = divisor_i >> 1;
      last_pos_c     = divisor_i - DW'(1);
      pos_c          = restart_i ? '0 : phase_q;
      phase_d        = '0;
      out_d          = 1'b0;
      if (running_c && !force_low_i) begin
         out_d   = (pos_c < half_c);
         phase_d = (pos_c == last_pos_c) ? '0 : pos_c + DW'(1);
      end
      period_end_c_o = running_c && (phase_q == last_pos_c);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         phase_q <= '0;
         out_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         out_q   <= out_d;
      end
   end

   assign clock_out_o = out_q;

endmodule

// File: rtl/glitch_free_clock_divider.sv
// Clock divider whose ratio changes only at period boundaries, with a
// forced-low idle gap between the old and the new ratio.
module glitch_free_clock_divider
   import glitch_free_clock_divider_package::*;
#(
   parameter int unsigned DIVISOR_WIDTH = 8,
   parameter int unsigned RESET_DIVISOR = 2,
   parameter int unsigned IDLE_CYCLES   = 1
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [DIVISOR_WIDTH-1:0] divisor_i,
   input  logic                     request_i,
   output logic                     busy_o,
   output logic [DIVISOR_WIDTH-1:0] current_divisor_o,
   output logic                     clock_out_o
);

   localparam int unsigned DW = DIVISOR_WIDTH;
   localparam int unsigned IW = IDLE_CNT_WIDTH;

   switch_state_e state_q, state_d;
   logic [DW-1:0] cur_q, cur_d;
   logic [DW-1:0] pend_q, pend_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] div_sel_c;
   logic          apply_c, force_low_c, period_end_c, accept_c, stopped_c;

   // Apply decision depends only on registered state, keeping the counter loop acyclic.
   always_comb begin
      apply_c     = (state_q == IDLE_GAP) && (idle_q >= IW'(IDLE_CYCLES));
      force_low_c = (state_q == IDLE_GAP) && !apply_c;
      div_sel_c   = apply_c ? pend_q : cur_q;
   end

   clock_divider_phase_counter #(
      .DIVISOR_WIDTH (DIVISOR_WIDTH)
   ) u_phase_counter (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .divisor_i      (div_sel_c),
      .restart_i      (apply_c),
      .force_low_i    (force_low_c),
      .period_end_c_o (period_end_c),
      .clock_out_o    (clock_out_o)
   );

   // Switch FSM: next state and pending/current divisor updates.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      pend_d    = pend_q;
      idle_d    = idle_q;
      accept_c  = request_i && !busy_q;
      stopped_c = (cur_q < DW'(STOP_THRESHOLD));
      unique case (state_q)
         RUNNING: begin
            if (accept_c) begin
               pend_d = divisor_i;
               if (stopped_c) begin
                  // The cycle after acceptance already counts as the first idle cycle.
                  state_d = IDLE_GAP;
                  idle_d  = IW'(1);
               end else if (period_end_c) begin
                  state_d = IDLE_GAP;
                  idle_d  = '0;
               end else begin
                  state_d = DRAINING;
               end
            end
         end
         DRAINING: begin
            if (period_end_c) begin
               state_d = IDLE_GAP;
               idle_d  = '0;
            end
         end
         IDLE_GAP: begin
            if (apply_c) begin
               cur_d   = pend_q;
               state_d = RUNNING;
            end else begin
               idle_d = idle_q + IW'(1);
            end
         end
         default: state_d = RUNNING;
      endcase
      busy_d = (state_d != RUNNING);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= RUNNING;
         cur_q   <= DW'(RESET_DIVISOR);
         pend_q  <= DW'(RESET_DIVISOR);
         idle_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         pend_q  <= pend_d;
         idle_q  <= idle_d;
         busy_q  <= busy_d;
      end
   end

   assign busy_o            = busy_q;
   assign current_divisor_o = cur_q;

endmodule
